// File: rtl/mem_port_arbiter.sv
// Shares one four-phase handshake memory port among NUM_PORTS requesters,
// using round-robin or fixed-priority arbitration selected by RR_MODE.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int RR_MODE   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
    output logic                          mem_enable,
    output logic                          mem_rw,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack
);

    localparam int GW = $clog2(NUM_PORTS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           r_state;
    logic [GW-1:0]        r_ptr;
    logic [GW-1:0]        r_grant_id;
    logic [NUM_PORTS-1:0] r_ack;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_mem_enable;
    logic                 r_mem_rw;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;

    logic [GW-1:0]        w_winner;
    logic                 w_found;
    int                   w_idx;
    logic [NUM_PORTS-1:0] w_ack_onehot;

    // Round-robin scans from the port after the last winner; fixed priority scans from port 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = (RR_MODE != 0) ? (int'(r_ptr) + 1 + i) % NUM_PORTS : i;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = GW'(w_idx);
            end
        end
    end

    always_comb begin
        w_ack_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_ack_onehot[i] = (r_grant_id == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, because every output must read zero after reset.
        if (!reset) begin
            r_state      <= IDLE;
            r_ptr        <= GW'(NUM_PORTS - 1);
            r_grant_id   <= '0;
            r_ack        <= '0;
            r_rdata      <= '0;
            r_mem_enable <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_mem_addr   <= addr[w_winner*ADDR_W +: ADDR_W];
                        r_mem_wdata  <= wdata[w_winner*DATA_W +: DATA_W];
                        r_mem_rw     <= we[w_winner];
                        r_grant_id   <= w_winner;
                        r_mem_enable <= 1'b1;
                        if (RR_MODE != 0) begin
                            r_ptr <= w_winner;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        if (!r_mem_rw) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack        <= w_ack_onehot;
                        r_mem_enable <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    // Four-phase: stay until memory withdraws its acknowledge.
                    r_ack <= '0;
                    if (!mem_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign busy       = (r_state != IDLE);
    assign grant_id   = r_grant_id;
    assign mem_enable = r_mem_enable;
    assign mem_rw     = r_mem_rw;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
